// File: rtl/parity_ram_pkg.sv
// Shared types and helpers for the parity RAM: FSM states, read-during-write
// encodings and the parity function.
package parity_ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  // Widest word parity_of accepts; callers zero-extend, which leaves parity unchanged.
  localparam int unsigned PAR_MAX_W = 256;

  function automatic logic parity_of(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/parity_ram_array.sv
// Storage array with one synchronous write port and a read-port mux that
// applies the read-during-write policy; the read register lives in the parent.
module parity_ram_array
  import parity_ram_pkg::*;
#(
  parameter int unsigned WORD_W   = 9,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 2**ADDR_W,
  parameter int unsigned RDW_MODE = RDW_READ_FIRST
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_word_c
);

  localparam int unsigned CMP_W = ADDR_W + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              rd_ok;
  logic              bypass;

  assign wr_ok  = wr_en & ({1'b0, wr_addr} < CMP_W'(DEPTH));
  assign rd_ok  = {1'b0, rd_addr} < CMP_W'(DEPTH);
  assign bypass = (RDW_MODE == RDW_WRITE_FIRST) && wr_ok && (wr_addr == rd_addr);

  // Out-of-range writes are dropped here so the parent need not filter them.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Out-of-range reads return zeros, which also carry good parity.
  always_comb begin
    rd_word_c = '0;
    if (rd_ok) begin
      rd_word_c = bypass ? wr_word : mem[rd_addr];
    end
  end

endmodule

// File: rtl/parity_ram.sv
// Parity-protected RAM: power-up clear sweep, registered one-cycle read with
// parity check, error injection on write and a saturating error counter.
module parity_ram
  import parity_ram_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 2**ADDR_W,
  parameter int unsigned RDW_MODE = RDW_READ_FIRST,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              inj_err,
  output logic [DATA_W:0]   data_out,
  output logic              rd_valid,
  output logic              ready,
  output logic              parity_err,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned WORD_W = DATA_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              ready_nxt;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_word;
  logic              rd_en;
  logic [WORD_W-1:0] rd_word_c;
  logic              rd_bad;

  parity_ram_array #(
    .WORD_W  (WORD_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RDW_MODE(RDW_MODE)
  ) u_array (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_word  (wr_word),
    .rd_addr  (address),
    .rd_word_c(rd_word_c)
  );

  // Next state, sweep pointer and array port steering.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    ready_nxt = ready;
    wr_en     = 1'b0;
    wr_addr   = address;
    wr_word   = {parity_of(PAR_MAX_W'(data_in)) ^ inj_err, data_in};
    rd_en     = 1'b0;
    case (state)
      INIT: begin
        wr_en   = 1'b1;
        wr_addr = ptr;
        wr_word = '0;
        if (ptr == LAST_ADDR) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end else begin
          ptr_nxt = ptr + ADDR_W'(1);
        end
      end
      RUN: begin
        wr_en = write;
        rd_en = read;
      end
      default: begin
        state_nxt = INIT;
        ptr_nxt   = '0;
        ready_nxt = 1'b0;
      end
    endcase
  end

  assign rd_bad = rd_en & parity_of(PAR_MAX_W'(rd_word_c));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      ptr   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      ready <= ready_nxt;
    end
  end

  // Read return path; data_out holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      rd_valid   <= 1'b0;
      parity_err <= 1'b0;
      err_count  <= '0;
    end else begin
      rd_valid   <= rd_en;
      parity_err <= rd_bad;
      if (rd_en) begin
        data_out <= rd_word_c;
      end
      if (rd_bad && (err_count != CNT_MAX)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_ram.sv
// Bench for parity_ram: one read-first instance (2-bit counter) and one
// write-first instance (8-bit counter) driven in lockstep against a word model.
module tb_parity_ram;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 5;
  localparam int unsigned DEP = 16;

  logic          clk = 1'b0;
  logic          rst, write, read, inj_err;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;

  logic [DW:0] dout0, dout1;
  logic        v0, v1, rdy0, rdy1, pe0, pe1;
  logic [1:0]  cnt0;
  logic [7:0]  cnt1;

  always #5 clk = ~clk;

  parity_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RDW_MODE(0), .CNT_W(2)) u_rf (
    .clk(clk), .rst(rst), .write(write), .read(read), .address(address),
    .data_in(data_in), .inj_err(inj_err), .data_out(dout0), .rd_valid(v0),
    .ready(rdy0), .parity_err(pe0), .err_count(cnt0)
  );

  parity_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RDW_MODE(1), .CNT_W(8)) u_wf (
    .clk(clk), .rst(rst), .write(write), .read(read), .address(address),
    .data_in(data_in), .inj_err(inj_err), .data_out(dout1), .rd_valid(v1),
    .ready(rdy1), .parity_err(pe1), .err_count(cnt1)
  );

  int errors = 0;
  int checks = 0;

  logic [DW:0] mem [DEP];
  logic [DW:0] last0, last1;
  int          mc0, mc1;
  bit          mready;
  int          init_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW:0] word_of(input logic [DW-1:0] d, input bit inj);
    return {(^d) ^ inj, d};
  endfunction

  // One clock of stimulus; model computed from the rules, then all outputs compared.
  task automatic cyc(input bit w, input bit r, input int a, input logic [DW-1:0] d, input bit inj);
    logic [DW:0] e0, e1, nw;
    bit inr, rd_ok;
    write = w; read = r; address = AW'(a); data_in = d; inj_err = inj;
    inr   = (a < DEP);
    nw    = word_of(d, inj);
    rd_ok = r && mready;
    e0 = '0;
    e1 = '0;
    if (rd_ok && inr) begin
      e0 = mem[a];
      e1 = w ? nw : mem[a];
    end
    @(posedge clk); #1;
    if (w && mready && inr) mem[a] = nw;
    if (rd_ok) begin
      last0 = e0;
      last1 = e1;
      if (^e0 && mc0 < 3)   mc0++;
      if (^e1 && mc1 < 255) mc1++;
    end
    if (!mready) begin
      init_left--;
      if (init_left == 0) mready = 1'b1;
    end
    chk("rd_valid_rf", 32'(v0), 32'(rd_ok));
    chk("rd_valid_wf", 32'(v1), 32'(rd_ok));
    chk("data_out_rf", 32'(dout0), 32'(last0));
    chk("data_out_wf", 32'(dout1), 32'(last1));
    chk("parity_err_rf", 32'(pe0), 32'(rd_ok && (^e0)));
    chk("parity_err_wf", 32'(pe1), 32'(rd_ok && (^e1)));
    chk("err_count_rf", 32'(cnt0), 32'(mc0));
    chk("err_count_wf", 32'(cnt1), 32'(mc1));
    chk("ready_rf", 32'(rdy0), 32'(mready));
    chk("ready_wf", 32'(rdy1), 32'(mready));
  endtask

  // Applies rst for one edge with whatever requests are currently driven.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_rd_valid", 32'({v0, v1}), 32'(0));
    chk("rst_data_out", 32'({dout0, dout1}), 32'(0));
    chk("rst_ready", 32'({rdy0, rdy1}), 32'(0));
    chk("rst_parity_err", 32'({pe0, pe1}), 32'(0));
    chk("rst_err_count", 32'({cnt0, cnt1}), 32'(0));
    rst = 1'b0;
    for (int i = 0; i < DEP; i++) mem[i] = '0;
    last0 = '0; last1 = '0;
    mc0 = 0; mc1 = 0;
    mready = 1'b0;
    init_left = DEP;
  endtask

  initial begin
    write = 0; read = 0; address = '0; data_in = '0; inj_err = 0;
    do_reset();

    // Init sweep; a write and read issued mid-sweep must be ignored.
    cyc(1, 0, 7, 8'hFF, 0);
    cyc(0, 1, 7, 8'h00, 0);
    for (int i = 0; i < DEP - 2; i++) cyc(0, 0, 0, 8'h00, 0);

    cyc(0, 1, 5, 8'h00, 0);
    cyc(0, 1, 7, 8'h00, 0);

    cyc(1, 0, 3, 8'hA5, 0);
    cyc(0, 1, 3, 8'h00, 0);
    chk("read_a5", 32'(dout0), 32'h0A5);
    cyc(1, 0, 3, 8'h07, 0);
    cyc(0, 1, 3, 8'h00, 0);
    chk("read_07", 32'(dout0), 32'h107);

    // Injected parity error, repeated reads drive the counters to saturation.
    cyc(1, 0, 9, 8'h3C, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 9, 8'h00, 0);
      chk("inj_word", 32'(dout0), 32'h13C);
      chk("inj_pe", 32'(pe0), 32'(1));
    end
    chk("sat_rf", 32'(cnt0), 32'(3));
    chk("cnt_wf", 32'(cnt1), 32'(4));

    // Same-cycle read and write on one address.
    cyc(1, 0, 2, 8'h11, 0);
    cyc(1, 1, 2, 8'h22, 0);
    chk("rdw_rf", 32'(dout0), 32'h011);
    chk("rdw_wf", 32'(dout1), 32'h022);
    cyc(0, 1, 2, 8'h00, 0);

    // Write-first with injection on the returned word.
    cyc(1, 1, 4, 8'h81, 1);

    // Out-of-range address.
    cyc(1, 0, 17, 8'h5A, 0);
    cyc(0, 1, 17, 8'h00, 0);
    cyc(0, 1, 31, 8'h00, 0);

    // Reset coincident with a read request discards the read and re-clears memory.
    cyc(1, 0, 1, 8'h55, 0);
    write = 0; read = 1; address = AW'(1);
    do_reset();
    read = 0;
    for (int i = 0; i < DEP; i++) cyc(0, 0, 0, 8'h00, 0);
    cyc(0, 1, 1, 8'h00, 0);
    chk("post_rst_read", 32'(dout0), 32'h000);

    // Random traffic, including out-of-range addresses and injected errors.
    for (int i = 0; i < 400; i++) begin
      cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 19)), DW'($urandom), ($urandom_range(0, 3) == 0));
    end
    cyc(0, 0, 0, 8'h00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
